// File: rtl/color_centroid_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | color_centroid_if : RGB565 AXI4-Stream video beat bundle               |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface color_centroid_if;
  logic [15:0] S_AXIS_VIDEO_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_VIDEO_TREADY;
  logic        S_AXIS_VIDEO_TUSER;
  logic        S_AXIS_VIDEO_TLAST;

  modport master (
    output S_AXIS_VIDEO_TDATA, S_AXIS_TVALID, S_AXIS_VIDEO_TUSER, S_AXIS_VIDEO_TLAST,
    input  S_AXIS_VIDEO_TREADY
  );

  modport slave (
    input  S_AXIS_VIDEO_TDATA, S_AXIS_TVALID, S_AXIS_VIDEO_TUSER, S_AXIS_VIDEO_TLAST,
    output S_AXIS_VIDEO_TREADY
  );
endinterface
`default_nettype wire

// File: rtl/color_centroid.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | color_centroid : per-frame centroid of pixels inside an RGB window     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module color_centroid #(
  parameter  int X_RES     = 640,
  parameter  int Y_RES     = 480,
  parameter  int MIN_COUNT = 16,
  localparam int XW        = $clog2(X_RES),
  localparam int YW        = $clog2(Y_RES),
  localparam int CW        = $clog2(X_RES * Y_RES + 1),
  localparam int SUM_W     = CW + ((YW > XW) ? YW : XW)
) (
  input  wire logic            i_pclk,
  input  wire logic            i_resetn,
  input  wire logic            i_enable,
  color_centroid_if.slave      s_axis,
  input  wire logic [4:0]      i_r_min,
  input  wire logic [4:0]      i_r_max,
  input  wire logic [5:0]      i_g_min,
  input  wire logic [5:0]      i_g_max,
  input  wire logic [4:0]      i_b_min,
  input  wire logic [4:0]      i_b_max,
  output logic      [XW-1:0]   o_centroid_x,
  output logic      [YW-1:0]   o_centroid_y,
  output logic      [CW-1:0]   o_count,
  output logic                 o_found,
  output logic                 o_valid,
  output logic                 o_busy
);

  localparam int DCW = $clog2(SUM_W + 1);
  localparam logic [XW-1:0]  X_LAST   = XW'(X_RES - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(Y_RES - 1);
  localparam logic [CW-1:0]  CNT_MIN  = CW'(MIN_COUNT);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(SUM_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DIVIDE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state, w_next;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic [SUM_W-1:0]   r_sum_x, r_sum_y;
  logic [CW-1:0]      r_count;
  logic [SUM_W-1:0]   r_qx, r_qy;
  logic [CW-1:0]      r_rx, r_ry;
  logic [DCW-1:0]     r_div_cnt;
  logic               r_busy, r_valid;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [CW+SUM_W-1:0] f_div_step(
    input logic [CW-1:0]    rem,
    input logic [SUM_W-1:0] quo,
    input logic [CW-1:0]    div
  );
    logic [CW:0] sh;
    logic [CW:0] diff;
    sh   = {rem, quo[SUM_W-1]};
    diff = sh - {1'b0, div};
    if (sh >= {1'b0, div}) return {diff[CW-1:0], quo[SUM_W-2:0], 1'b1};
    else                   return {sh[CW-1:0],   quo[SUM_W-2:0], 1'b0};
  endfunction

  logic [15:0] w_d;
  logic [4:0]  w_r, w_b;
  logic [5:0]  w_g;
  logic        w_match, w_restart, w_take, w_frame_end, w_detect;
  logic [XW-1:0]    w_px;
  logic [YW-1:0]    w_py;
  logic [SUM_W-1:0] w_sx_next, w_sy_next;
  logic [CW-1:0]    w_cnt_next;
  logic [CW+SUM_W-1:0] w_stx, w_sty;

  assign s_axis.S_AXIS_VIDEO_TREADY = 1'b1;

  assign w_d     = s_axis.S_AXIS_VIDEO_TDATA;
  assign w_r     = w_d[7:3];
  assign w_g     = {w_d[2:0], w_d[15:13]};
  assign w_b     = w_d[12:8];
  assign w_match = (w_r >= i_r_min) && (w_r <= i_r_max) &&
                   (w_g >= i_g_min) && (w_g <= i_g_max) &&
                   (w_b >= i_b_min) && (w_b <= i_b_max);

  // A start-of-frame beat seen while collecting restarts from pixel (0,0).
  assign w_restart = s_axis.S_AXIS_TVALID && s_axis.S_AXIS_VIDEO_TUSER &&
                     ((r_state == S_IDLE) || (r_state == S_ACCUM));
  assign w_take    = s_axis.S_AXIS_TVALID && ((r_state == S_ACCUM) || w_restart);
  assign w_px      = w_restart ? '0 : r_x;
  assign w_py      = w_restart ? '0 : r_y;
  assign w_sx_next = (w_restart ? '0 : r_sum_x) + (w_match ? SUM_W'(w_px) : '0);
  assign w_sy_next = (w_restart ? '0 : r_sum_y) + (w_match ? SUM_W'(w_py) : '0);
  assign w_cnt_next = (w_restart ? '0 : r_count) + (w_match ? CW'(1) : '0);
  assign w_frame_end = w_take && s_axis.S_AXIS_VIDEO_TLAST && (w_py == Y_LAST);
  assign w_detect  = (w_cnt_next >= CNT_MIN);

  assign w_stx = f_div_step(r_rx, r_qx, r_count);
  assign w_sty = f_div_step(r_ry, r_qy, r_count);

  always_comb begin
    w_next = r_state;
    if (!i_enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_take) begin
            if (w_frame_end) w_next = w_detect ? S_DIVIDE : S_DONE;
            else             w_next = S_ACCUM;
          end
        end
        S_DIVIDE: if (r_div_cnt == DIV_LAST) w_next = S_DONE;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_resetn) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_ff @(posedge i_pclk) begin
    if (!i_resetn) begin
      r_x <= '0; r_y <= '0; r_sum_x <= '0; r_sum_y <= '0; r_count <= '0;
      r_qx <= '0; r_qy <= '0; r_rx <= '0; r_ry <= '0; r_div_cnt <= '0;
      r_busy <= 1'b0; r_valid <= 1'b0;
      o_centroid_x <= '0; o_centroid_y <= '0; o_count <= '0; o_found <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_busy  <= (w_next == S_ACCUM) || (w_next == S_DIVIDE);
      if (!i_enable) begin
        r_x <= '0; r_y <= '0; r_sum_x <= '0; r_sum_y <= '0; r_count <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_ACCUM: begin
            if (w_take) begin
              r_sum_x <= w_sx_next;
              r_sum_y <= w_sy_next;
              r_count <= w_cnt_next;
              if (s_axis.S_AXIS_VIDEO_TLAST) begin
                r_x <= '0;
                r_y <= w_frame_end ? '0 : w_py + YW'(1);
              end else begin
                r_x <= (w_px == X_LAST) ? w_px : w_px + XW'(1);
                r_y <= w_py;
              end
              if (w_frame_end) begin
                r_qx <= w_sx_next; r_rx <= '0;
                r_qy <= w_sy_next; r_ry <= '0;
                r_div_cnt <= '0;
              end
            end else if (r_state == S_IDLE) begin
              r_x <= '0; r_y <= '0; r_sum_x <= '0; r_sum_y <= '0; r_count <= '0;
            end
          end
          S_DIVIDE: begin
            {r_rx, r_qx} <= w_stx;
            {r_ry, r_qy} <= w_sty;
            r_div_cnt    <= r_div_cnt + DCW'(1);
          end
          S_DONE: begin
            r_valid      <= 1'b1;
            o_count      <= r_count;
            o_found      <= (r_count >= CNT_MIN);
            o_centroid_x <= (r_count >= CNT_MIN) ? r_qx[XW-1:0] : '0;
            o_centroid_y <= (r_count >= CNT_MIN) ? r_qy[YW-1:0] : '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_valid = r_valid;
  assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_color_centroid.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_color_centroid : directed frames on a 16x12 image, MIN_COUNT=16     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_color_centroid;
  localparam int X_RES = 16, Y_RES = 12, MIN_COUNT = 16;
  localparam int SUM_W = 12;

  logic       clk = 1'b0;
  logic       resetn, enable;
  logic [4:0] r_min, r_max, b_min, b_max;
  logic [5:0] g_min, g_max;
  logic [3:0] cx, cy;
  logic [7:0] cnt;
  logic       found, valid, busy;

  always #5 clk = ~clk;

  color_centroid_if bus ();

  color_centroid #(.X_RES(X_RES), .Y_RES(Y_RES), .MIN_COUNT(MIN_COUNT)) dut (
    .i_pclk(clk), .i_resetn(resetn), .i_enable(enable), .s_axis(bus.slave),
    .i_r_min(r_min), .i_r_max(r_max), .i_g_min(g_min), .i_g_max(g_max),
    .i_b_min(b_min), .i_b_max(b_max),
    .o_centroid_x(cx), .o_centroid_y(cy), .o_count(cnt),
    .o_found(found), .o_valid(valid), .o_busy(busy)
  );

  int cyc = 0;
  int n_strobe = 0;
  int strobe_cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int t_last = 0;
  int t_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_strobe   <= n_strobe + 1;
      strobe_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic u, input logic l);
    @(negedge clk);
    bus.S_AXIS_VIDEO_TDATA = d;
    bus.S_AXIS_TVALID      = 1'b1;
    bus.S_AXIS_VIDEO_TUSER = u;
    bus.S_AXIS_VIDEO_TLAST = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.S_AXIS_TVALID      = 1'b0;
      bus.S_AXIS_VIDEO_TUSER = 1'b0;
      bus.S_AXIS_VIDEO_TLAST = 1'b0;
      bus.S_AXIS_VIDEO_TDATA = 16'h0000;
    end
  endtask

  // Red block x0..x1, y0..y1 on black; the edge after the final beat is cycle t_last.
  task automatic rows(input int x0, input int x1, input int y0, input int y1, input int nrows);
    for (int y = 0; y < nrows; y++) begin
      for (int x = 0; x < X_RES; x++) begin
        beat((x >= x0 && x <= x1 && y >= y0 && y <= y1) ? 16'h00F8 : 16'h0000,
             (x == 0 && y == 0), (x == X_RES - 1));
      end
    end
    t_last = cyc + 1;
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b1;
    r_min = 5'd24; r_max = 5'd31;
    g_min = 6'd0;  g_max = 6'd15;
    b_min = 5'd0;  b_max = 5'd8;
    bus.S_AXIS_TVALID = 1'b0; bus.S_AXIS_VIDEO_TUSER = 1'b0;
    bus.S_AXIS_VIDEO_TLAST = 1'b0; bus.S_AXIS_VIDEO_TDATA = 16'h0000;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_cx", 32'(cx), 0);
    chk("rst_cy", 32'(cy), 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tready", 32'(bus.S_AXIS_VIDEO_TREADY), 1);

    for (int i = 0; i < 20; i++) beat(i[0] ? 16'h00F8 : 16'h0000, 1'b0, (i % 16) == 15);
    idle(5);
    chk("nosof_strobes", n_strobe, 0);
    chk("nosof_busy", 32'(busy), 0);

    rows(4, 7, 3, 6, Y_RES);
    idle(2);
    chk("basic_busy_div", 32'(busy), 1);
    idle(20);
    chk("basic_strobes", n_strobe, 1);
    chk("basic_timing", strobe_cyc, t_last + SUM_W + 1);
    chk("basic_count", 32'(cnt), 16);
    chk("basic_cx", 32'(cx), 5);
    chk("basic_cy", 32'(cy), 4);
    chk("basic_found", 32'(found), 1);
    chk("basic_busy_end", 32'(busy), 0);

    rows(4, 6, 3, 5, Y_RES);
    idle(20);
    chk("low_strobes", n_strobe, 2);
    chk("low_timing", strobe_cyc, t_last + 1);
    chk("low_count", 32'(cnt), 9);
    chk("low_found", 32'(found), 0);
    chk("low_cx", 32'(cx), 0);
    chk("low_cy", 32'(cy), 0);

    rows(4, 7, 3, 6, Y_RES);
    idle(20);
    chk("b2b_a_strobes", n_strobe, 3);
    chk("b2b_a_cx", 32'(cx), 5);
    rows(10, 13, 3, 6, Y_RES);
    t_b = t_last;
    rows(4, 7, 3, 6, Y_RES);
    idle(20);
    chk("b2b_strobes", n_strobe, 4);
    chk("b2b_timing", strobe_cyc, t_b + SUM_W + 1);
    chk("b2b_cx", 32'(cx), 11);
    chk("b2b_cy", 32'(cy), 4);
    chk("b2b_count", 32'(cnt), 16);

    rows(10, 13, 3, 6, 5);
    rows(4, 7, 3, 6, Y_RES);
    idle(20);
    chk("resync_strobes", n_strobe, 5);
    chk("resync_count", 32'(cnt), 16);
    chk("resync_cx", 32'(cx), 5);
    chk("resync_cy", 32'(cy), 4);

    rows(10, 13, 3, 6, Y_RES);
    idle(3);
    enable = 1'b0;
    idle(2);
    chk("en_busy", 32'(busy), 0);
    enable = 1'b1;
    idle(30);
    chk("en_strobes", n_strobe, 5);
    chk("en_hold_cx", 32'(cx), 5);
    chk("en_hold_count", 32'(cnt), 16);
    chk("en_hold_found", 32'(found), 1);
    rows(10, 13, 3, 6, Y_RES);
    idle(20);
    chk("reen_strobes", n_strobe, 6);
    chk("reen_timing", strobe_cyc, t_last + SUM_W + 1);
    chk("reen_cx", 32'(cx), 11);
    chk("reen_cy", 32'(cy), 4);
    chk("reen_count", 32'(cnt), 16);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
